// File: rtl/port_read_scheduler.sv
// rtl/port_read_scheduler.sv - per-port read scheduler: pending counters, chain-manager request, word streaming
// Optional round-robin priority pick: define PORT_SCHED_RR_EN.
module port_read_scheduler #(
   parameter int PORT_ID = 0,
   parameter int DATA_W  = 16,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enq_valid,
   input  logic [2:0]        enq_priority,
   input  logic [3:0]        enq_dest_port,
   output logic              port_rea,
   output logic [3:0]        port_priority,
   input  logic              rd_len_valid,
   input  logic [7:0]        rd_len,
   output logic              word_rea,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sop,
   output logic              out_eop,
   input  logic              out_ready,
   output logic              len_err,
   output logic              cnt_ovf
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_LEN, STREAM} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            state;
   logic [CNT_W-1:0]  cnt [8];
   logic [2:0]        sel;
   logic [7:0]        remain;
   logic              first;
   logic              inflight;
   logic              inflight_sop;
   logic              inflight_eop;
   logic [DATA_W+1:0] fifo [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        occ;

   logic              enq_hit;
   logic [7:0]        enq_inc;
   logic [7:0]        deq;
   logic [7:0]        nonempty;
   logic [2:0]        srch_start;
   logic [2:0]        pick_idx;
   logic              store;
   logic              mem_pop;
   logic [1:0]        occ_nxt;
   logic [7:0]        remain_nxt;
   logic              stream_nxt;
   logic              word_rea_nxt;
   logic              eop_hs;
   logic [DATA_W+1:0] head;

`ifdef PORT_SCHED_RR_EN
   logic [2:0] last_sel;
   assign srch_start = last_sel + 3'd1;
`else
   assign srch_start = 3'd0;
`endif

   // First nonempty queue at or after start, wrapping modulo 8.
   function automatic logic [2:0] pick(input logic [7:0] ne, input logic [2:0] start);
      logic [2:0] idx;
      pick = start;
      for (int k = 7; k >= 0; k--) begin
         idx = start + 3'(k);
         if (ne[idx]) pick = idx;
      end
   endfunction

   assign enq_hit = enq_valid && (enq_dest_port == 4'(PORT_ID));
   assign pick_idx = pick(nonempty, srch_start);

   always_comb begin
      enq_inc  = '0;
      deq      = '0;
      nonempty = '0;
      for (int i = 0; i < 8; i++) begin
         enq_inc[i]  = enq_hit && (enq_priority == 3'(i));
         deq[i]      = (state == REQ) && (sel == 3'(i));
         nonempty[i] = (cnt[i] != '0);
      end
   end

   // The head word bypasses the FIFO when it is empty, so a returned word is visible the cycle it arrives.
   assign head      = (occ != 2'd0) ? fifo[rd_ptr] : {inflight_eop, inflight_sop, rd_data};
   assign out_valid = (occ != 2'd0) || inflight;
   assign out_data  = out_valid ? head[DATA_W-1:0] : '0;
   assign out_sop   = out_valid && head[DATA_W];
   assign out_eop   = out_valid && head[DATA_W+1];
   assign eop_hs    = out_valid && out_ready && out_eop;

   always_comb begin
      store   = inflight && !((occ == 2'd0) && out_ready);
      mem_pop = (occ != 2'd0) && out_ready;
      occ_nxt = occ + {1'b0, store} - {1'b0, mem_pop};
      remain_nxt = remain;
      if (state == WAIT_LEN && rd_len_valid && rd_len != 8'd0)
         remain_nxt = rd_len;
      else if (word_rea)
         remain_nxt = remain - 8'd1;
      stream_nxt = ((state == STREAM) && !eop_hs) ||
                   ((state == WAIT_LEN) && rd_len_valid && (rd_len != 8'd0));
      // word_rea is registered, so the credit check uses next-cycle occupancy and in-flight count.
      word_rea_nxt = stream_nxt && (remain_nxt != 8'd0) &&
                     (({1'b0, occ_nxt} + {2'b00, word_rea}) < 3'd2);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         for (int i = 0; i < 8; i++) cnt[i] <= '0;
         sel           <= '0;
         remain        <= '0;
         first         <= 1'b0;
         inflight      <= 1'b0;
         inflight_sop  <= 1'b0;
         inflight_eop  <= 1'b0;
         fifo[0]       <= '0;
         fifo[1]       <= '0;
         wr_ptr        <= 1'b0;
         rd_ptr        <= 1'b0;
         occ           <= '0;
         port_rea      <= 1'b0;
         port_priority <= '0;
         word_rea      <= 1'b0;
         len_err       <= 1'b0;
         cnt_ovf       <= 1'b0;
`ifdef PORT_SCHED_RR_EN
         last_sel      <= 3'd7;
`endif
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (enq_inc[i] && !deq[i]) begin
               if (cnt[i] == CNT_MAX) cnt_ovf <= 1'b1;
               else                   cnt[i]  <= cnt[i] + 1'b1;
            end else if (deq[i] && !enq_inc[i]) begin
               cnt[i] <= cnt[i] - 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (|nonempty) begin
                  sel           <= pick_idx;
                  port_rea      <= 1'b1;
                  port_priority <= {1'b0, pick_idx};
`ifdef PORT_SCHED_RR_EN
                  last_sel      <= pick_idx;
`endif
                  state         <= REQ;
               end
            end
            REQ: begin
               port_rea      <= 1'b0;
               port_priority <= '0;
               state         <= WAIT_LEN;
            end
            WAIT_LEN: begin
               if (rd_len_valid) begin
                  if (rd_len == 8'd0) begin
                     len_err <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     first <= 1'b1;
                     state <= STREAM;
                  end
               end
            end
            STREAM: begin
               if (eop_hs) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         remain   <= remain_nxt;
         word_rea <= word_rea_nxt;
         inflight <= word_rea;
         if (word_rea) begin
            first        <= 1'b0;
            inflight_sop <= first;
            inflight_eop <= (remain == 8'd1);
         end

         if (store) begin
            fifo[wr_ptr] <= {inflight_eop, inflight_sop, rd_data};
            wr_ptr       <= ~wr_ptr;
         end
         if (mem_pop) rd_ptr <= ~rd_ptr;
         occ <= occ_nxt;
      end
   end

endmodule

// File: tb/tb_port_read_scheduler.sv
// tb/tb_port_read_scheduler.sv - scoreboard bench for port_read_scheduler with chain-manager and buffer models
module tb_port_read_scheduler;
   localparam int DATA_W = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              enq_valid = 1'b0;
   logic [2:0]        enq_priority = '0;
   logic [3:0]        enq_dest_port = '0;
   logic              port_rea;
   logic [3:0]        port_priority;
   logic              rd_len_valid = 1'b0;
   logic [7:0]        rd_len = '0;
   logic              word_rea;
   logic [DATA_W-1:0] rd_data = '0;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_sop;
   logic              out_eop;
   logic              out_ready = 1'b1;
   logic              len_err;
   logic              cnt_ovf;

   port_read_scheduler #(.PORT_ID(0), .DATA_W(DATA_W), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .enq_valid(enq_valid), .enq_priority(enq_priority), .enq_dest_port(enq_dest_port),
      .port_rea(port_rea), .port_priority(port_priority),
      .rd_len_valid(rd_len_valid), .rd_len(rd_len),
      .word_rea(word_rea), .rd_data(rd_data),
      .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
      .out_ready(out_ready), .len_err(len_err), .cnt_ovf(cnt_ovf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [17:0] exp_q [$];
   logic [3:0]  exp_req [$];
   logic [7:0]  len_q [$];
   logic [7:0]  id_q [$];
   int checks = 0;
   int errors = 0;
   int next_id = 0;
   bit hold = 0, toggle = 0, gap_chk = 0, occ_chk = 0, mem_pend = 0, prev_rea = 0;
   int outst = 0, eop_cyc = -100, last_hs = -100;
   logic [7:0] cur_id = '0, widx = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_pkt(input logic [3:0] prio, input int len);
      exp_req.push_back(prio);
      len_q.push_back(len[7:0]);
      id_q.push_back(next_id[7:0]);
      for (int w = 1; w <= len; w++)
         exp_q.push_back({next_id[7:0], w[7:0], (w == 1), (w == len)});
      next_id++;
   endtask

   task automatic enq(input logic [2:0] p, input logic [3:0] d);
      enq_valid = 1'b1; enq_priority = p; enq_dest_port = d;
      @(posedge clk); #1;
      enq_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || exp_req.size() != 0) && n < budget) begin
         @(posedge clk); #1; n++;
      end
      repeat (3) begin @(posedge clk); #1; end
      chk("drain_words", exp_q.size(), 0);
      chk("drain_reqs", exp_req.size(), 0);
   endtask

   // Buffer: word returned one cycle after word_rea.
   initial forever begin
      @(negedge clk);
      mem_pend = word_rea && !rst;
      @(posedge clk); #1;
      if (mem_pend) begin
         widx = widx + 8'd1;
         rd_data = {cur_id, widx};
      end
   end

   // Chain manager: checks requested priority, answers with the queued length.
   initial forever begin
      logic [7:0] ln, id;
      @(negedge clk);
      if (!rst && port_rea) begin
         if (exp_req.size() == 0) begin
            checks++; errors++;
            $display("FAIL req_extra: got prio %0d expected none", port_priority);
         end else chk("req_prio", port_priority, exp_req.pop_front());
         if (gap_chk) chk("pkt_gap", cyc - eop_cyc, 2);
         ln = (len_q.size() != 0) ? len_q.pop_front() : 8'd1;
         id = (id_q.size() != 0) ? id_q.pop_front() : 8'hee;
         @(posedge clk); #1;
         while (hold) begin @(posedge clk); #1; end
         rd_len_valid = 1'b1; rd_len = ln; cur_id = id; widx = '0;
         @(posedge clk); #1;
         rd_len_valid = 1'b0;
      end
   end

   initial forever begin
      @(posedge clk); #1;
      out_ready = toggle ? !out_ready : 1'b1;
   end

   // Output monitor.
   initial forever begin
      @(negedge clk);
      if (rst) begin
         prev_rea = 0; outst = 0;
      end else begin
         if (port_rea) chk("rea_one_cycle", prev_rea, 0);
         prev_rea = port_rea;
         if (occ_chk) chk("outstanding_le2", (outst <= 2), 1);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL word_extra: got %0h expected none", out_data);
            end else chk("word", {out_data, out_sop, out_eop}, exp_q.pop_front());
            if (gap_chk && !out_sop) chk("contiguous", cyc - last_hs, 1);
            last_hs = cyc;
            if (out_eop) eop_cyc = cyc;
         end
         outst = outst + int'(word_rea) - int'(out_valid && out_ready);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      @(posedge clk); #1;
      chk("rst_port_rea", port_rea, 0);
      chk("rst_word_rea", word_rea, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_flags", {len_err, cnt_ovf}, 0);
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;

      // Three prio-0 packets.
      repeat (3) push_pkt(0, 4);
      enq(0, 0);
      chk("no_early_rea", port_rea, 0);
      enq(0, 0);
      enq(0, 0);
      wait_drain(300);

      // Three 60-word packets at full rate; first one held while the others queue.
      hold = 1;
      push_pkt(3, 60);
      enq(3, 0);
      push_pkt(0, 60);
      push_pkt(2, 60);
      enq(2, 0);
      enq(0, 0);
      repeat (2) begin @(posedge clk); #1; end
      gap_chk = 1;
      hold = 0;
      wait_drain(1000);
      gap_chk = 0;

      // Backpressure.
      toggle = 1; occ_chk = 1;
      push_pkt(4, 5);
      enq(4, 0);
      wait_drain(200);
      toggle = 0; occ_chk = 0;

      // Zero length.
      chk("len_err_clear", len_err, 0);
      push_pkt(1, 0);
      push_pkt(1, 3);
      enq(1, 0);
      enq(1, 0);
      wait_drain(200);
      chk("len_err_set", len_err, 1);

      // Foreign port ignored; counter saturation.
      repeat (4) enq(2, 4'd3);
      hold = 1;
      push_pkt(7, 1);
      enq(7, 0);
      repeat (4) begin @(posedge clk); #1; end
      for (int i = 0; i < 255; i++) enq(7, 0);
      chk("ovf_at_255", cnt_ovf, 0);
      enq(7, 0);
      chk("ovf_at_256", cnt_ovf, 1);
      for (int i = 0; i < 255; i++) push_pkt(7, 1);
      hold = 0;
      wait_drain(5000);

      // Two each of prio 0 and 5.
      hold = 1;
      push_pkt(0, 2);
      enq(0, 0);
      repeat (3) begin @(posedge clk); #1; end
`ifdef PORT_SCHED_RR_EN
      push_pkt(5, 2); push_pkt(0, 2); push_pkt(5, 2);
`else
      push_pkt(0, 2); push_pkt(5, 2); push_pkt(5, 2);
`endif
      enq(5, 0);
      enq(0, 0);
      enq(5, 0);
      hold = 0;
      wait_drain(300);

      // Reset mid-stream.
      push_pkt(6, 60);
      enq(6, 0);
      for (int n = 0; n < 200 && exp_q.size() > 50; n++) begin @(posedge clk); #1; end
      chk("mid_stream", (exp_q.size() <= 50), 1);
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 0);
      chk("arst_out_data", {out_data, out_sop, out_eop}, 0);
      chk("arst_reqs", {port_rea, port_priority, word_rea}, 0);
      chk("arst_flags", {len_err, cnt_ovf}, 0);
      exp_q.delete(); exp_req.delete(); len_q.delete(); id_q.delete();
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      chk("post_rst_idle", port_rea, 0);
      push_pkt(2, 3);
      enq(2, 0);
      wait_drain(200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
